// File: rtl/goal_seek_ctrl_pkg.sv
// Shared types for the goal-seek controller: state encoding, H-bridge drive
// codes and duty-select levels.
package goal_seek_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SWEEP   = 3'd1,
    ST_ALIGN_R = 3'd2,
    ST_ALIGN_L = 3'd3,
    ST_BACKOFF = 3'd4,
    ST_PAUSE   = 3'd5
  } state_e;

  typedef struct packed {
    logic fwd_a;
    logic fwd_b;
    logic bwd_a;
    logic bwd_b;
  } drive_t;

  localparam drive_t DRV_STOP  = 4'b0000;
  localparam drive_t DRV_SPIN  = 4'b1001;
  localparam drive_t DRV_LEFT  = 4'b0110;
  localparam drive_t DRV_BACK  = 4'b0011;

  typedef enum logic [1:0] {DUTY_MIN, DUTY_MID, DUTY_MAX} duty_e;

  function automatic drive_t drive_of(state_e s);
    case (s)
      ST_SWEEP, ST_ALIGN_R: return DRV_SPIN;
      ST_ALIGN_L:           return DRV_LEFT;
      ST_BACKOFF:           return DRV_BACK;
      default:              return DRV_STOP;
    endcase
  endfunction

  function automatic duty_e duty_of(state_e s);
    case (s)
      ST_ALIGN_R, ST_ALIGN_L: return DUTY_MID;
      ST_BACKOFF:             return DUTY_MAX;
      default:                return DUTY_MIN;
    endcase
  endfunction

  // min = 0, mid = MSB only, max = all ones, for any duty width
  function automatic logic [31:0] duty_code(duty_e d, int unsigned w);
    case (d)
      DUTY_MIN: return 32'd0;
      DUTY_MID: return 32'd1 << (w - 1);
      default:  return (32'd1 << w) - 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/goal_seek_ctrl_if.sv
// Sensor inputs and motor/status outputs of the goal-seek controller.
interface goal_seek_ctrl_if #(
  parameter int N_CH   = 2,
  parameter int DUTY_W = 2
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              enable;
  logic              pause;
  logic              inductance;
  logic [N_CH-1:0]   ir_hit;
  logic [SEL_W-1:0]  target_sel;
  logic              fwd_a, fwd_b, bwd_a, bwd_b;
  logic [DUTY_W-1:0] duty_a, duty_b;
  logic              done;
  logic              timeout;
  logic [2:0]        state_o;

  modport master (
    output enable, pause, inductance, ir_hit, target_sel,
    input  fwd_a, fwd_b, bwd_a, bwd_b, duty_a, duty_b, done, timeout, state_o
  );

  modport slave (
    input  enable, pause, inductance, ir_hit, target_sel,
    output fwd_a, fwd_b, bwd_a, bwd_b, duty_a, duty_b, done, timeout, state_o
  );
endinterface

// File: rtl/goal_seek_ctrl_rise_detect.sv
// Registered rising-edge detector; the reset value of the history register
// decides whether a level already high at reset release counts as an edge.
module rise_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) d_q <= RST_VAL;
    else     d_q <= d_i;

  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/goal_seek_ctrl.sv
// Goal-seek FSM: sweeps for the IR beacon, aligns on it, backs off the
// boundary wire, and can be paused or aborted at any time.
module goal_seek_ctrl
  import goal_seek_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int CNT_W          = 29,
  parameter int ALIGN_CYCLES   = 100_000_000,
  parameter int BACKOFF_CYCLES = 200_000_000,
  parameter int SWEEP_TIMEOUT  = 500_000_000,
  parameter int DUTY_W         = 2
) (
  input  logic           clk,
  input  logic           rst,
  goal_seek_ctrl_if.slave bus
);
  logic              en_rise;
  state_e            state_q, state_d, saved_q, saved_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc, cnt_lim;
  logic [N_CH-1:0]   tgt_mask;
  logic              tgt_hit, decoy_hit, done_d, timeout_d;
  drive_t            drv_q;
  logic [DUTY_W-1:0] duty_q;
  logic              done_q, timeout_q;

  // History resets high so an enable held through reset is not an edge
  rise_detect #(.RST_VAL(1'b1)) u_en_rise (
    .clk   (clk),
    .rst   (rst),
    .d_i   (bus.enable),
    .rise_o(en_rise)
  );

  always_comb begin
    tgt_mask = '0;
    if (32'(bus.target_sel) < N_CH) tgt_mask[bus.target_sel] = 1'b1;
  end

  assign tgt_hit   = |(bus.ir_hit & tgt_mask);
  assign decoy_hit = |(bus.ir_hit & ~tgt_mask);
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    case (state_q)
      ST_SWEEP:   cnt_lim = CNT_W'(SWEEP_TIMEOUT - 1);
      ST_BACKOFF: cnt_lim = CNT_W'(BACKOFF_CYCLES - 1);
      default:    cnt_lim = CNT_W'(ALIGN_CYCLES - 1);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    if (state_q != ST_IDLE && !bus.enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (en_rise) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
        // counter was held on entry, so resuming restores both state and count
        ST_PAUSE: if (!bus.pause) state_d = saved_q;
        default: begin
          if (bus.pause) begin
            state_d = ST_PAUSE;
            saved_d = state_q;
          end else if (bus.inductance && state_q != ST_BACKOFF) begin
            state_d = ST_BACKOFF;
            cnt_d   = '0;
          end else if (state_q == ST_SWEEP && (tgt_hit || decoy_hit)) begin
            state_d = tgt_hit ? ST_ALIGN_R : ST_ALIGN_L;
            cnt_d   = '0;
          end else if (cnt_q == cnt_lim) begin
            cnt_d = '0;
            case (state_q)
              ST_SWEEP: begin
                state_d   = ST_IDLE;
                timeout_d = 1'b1;
              end
              ST_BACKOFF: state_d = bus.inductance ? ST_BACKOFF : ST_SWEEP;
              default: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            endcase
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= ST_IDLE;
      saved_q   <= ST_IDLE;
      cnt_q     <= '0;
      drv_q     <= DRV_STOP;
      duty_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      cnt_q     <= cnt_d;
      drv_q     <= drive_of(state_d);
      duty_q    <= DUTY_W'(duty_code(duty_of(state_d), DUTY_W));
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end

  assign bus.fwd_a   = drv_q.fwd_a;
  assign bus.fwd_b   = drv_q.fwd_b;
  assign bus.bwd_a   = drv_q.bwd_a;
  assign bus.bwd_b   = drv_q.bwd_b;
  assign bus.duty_a  = duty_q;
  assign bus.duty_b  = duty_q;
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;
  assign bus.state_o = state_q;
endmodule
